// File: rtl/scr1_pipe_lsu_pl.sv
// Purpose: pipelined EXU-to-DMEM load/store unit. It keeps up to MAX_OUTST requests in flight,
//          tracked by an in-order tag FIFO, aligns byte lanes and reports misalign/access faults.
// Latency: all outputs are combinational from inputs and registered state; load-to-use is >= 1 cycle.
// Backpressure: a request waits while MAX_OUTST requests are outstanding, or until DMEM acknowledges it.
//          A misaligned request waits until every outstanding response has drained.
// Ports:   clk/rst_n (async, active-low). exu2lsu_* request, lsu2exu_* ack/response,
//          lsu2dmem_* request channel, dmem2lsu_* ack/response channel, lsu_busy.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package scr1_lsu_pl_pkg;
    localparam int SCR1_XLEN = 32;

    typedef enum logic [3:0] {
        SCR1_LSU_CMD_NONE = 4'd0,
        SCR1_LSU_CMD_LB   = 4'd1,
        SCR1_LSU_CMD_LH   = 4'd2,
        SCR1_LSU_CMD_LW   = 4'd3,
        SCR1_LSU_CMD_LBU  = 4'd4,
        SCR1_LSU_CMD_LHU  = 4'd5,
        SCR1_LSU_CMD_SB   = 4'd6,
        SCR1_LSU_CMD_SH   = 4'd7,
        SCR1_LSU_CMD_SW   = 4'd8
    } type_scr1_lsu_cmd_sel_e;

    typedef enum logic [3:0] {
        SCR1_EXC_CODE_INSTR_MISALIGN    = 4'd0,
        SCR1_EXC_CODE_INSTR_ACCESS_FAULT = 4'd1,
        SCR1_EXC_CODE_ILLEGAL_INSTR     = 4'd2,
        SCR1_EXC_CODE_BREAKPOINT        = 4'd3,
        SCR1_EXC_CODE_LD_ADDR_MISALIGN  = 4'd4,
        SCR1_EXC_CODE_LD_ACCESS_FAULT   = 4'd5,
        SCR1_EXC_CODE_ST_ADDR_MISALIGN  = 4'd6,
        SCR1_EXC_CODE_ST_ACCESS_FAULT   = 4'd7,
        SCR1_EXC_CODE_ECALL_M           = 4'd11
    } type_scr1_exc_code_e;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;
endpackage

module scr1_pipe_lsu_pl
    import scr1_lsu_pl_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = `SCR1_DMEM_AWIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  exu2lsu_req,
    input  logic [3:0]            exu2lsu_cmd,
    input  logic [SCR1_XLEN-1:0]  exu2lsu_addr,
    input  logic [SCR1_XLEN-1:0]  exu2lsu_s_data,
    output logic                  lsu2exu_req_ack,
    output logic                  lsu2exu_rdy,
    output logic [SCR1_XLEN-1:0]  lsu2exu_l_data,
    output logic                  lsu2exu_exc,
    output logic [3:0]            lsu2exu_exc_code,
    output logic                  lsu_busy,

    output logic                  lsu2dmem_req,
    output logic                  lsu2dmem_cmd,
    output logic [1:0]            lsu2dmem_width,
    output logic [ADDR_W-1:0]     lsu2dmem_addr,
    output logic [SCR1_XLEN-1:0]  lsu2dmem_wdata,
    input  logic                  dmem2lsu_req_ack,
    input  logic [SCR1_XLEN-1:0]  dmem2lsu_rdata,
    input  logic [1:0]            dmem2lsu_resp
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

    // Tag FIFO: command and byte offset of every request DMEM has accepted.
    logic [3:0]       tag_cmd [MAX_OUTST];
    logic [1:0]       tag_off [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic             req_is_store;
    logic             mis;
    logic             resp_any;
    logic             push;
    logic             pop;
    logic             mis_retire;
    logic [3:0]       head_cmd;
    logic [1:0]       head_off;
    logic             head_is_store;
    logic [SCR1_XLEN-1:0] shifted;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic is_store(input logic [3:0] c);
        return (c == SCR1_LSU_CMD_SB) || (c == SCR1_LSU_CMD_SH) || (c == SCR1_LSU_CMD_SW);
    endfunction

    // ---------------- request side ----------------
    always_comb begin
        req_is_store = is_store(exu2lsu_cmd);
        mis          = 1'b0;
        case (exu2lsu_cmd)
            SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH: mis = exu2lsu_addr[0];
            SCR1_LSU_CMD_LW, SCR1_LSU_CMD_SW:                   mis = |exu2lsu_addr[1:0];
            default:                                            mis = 1'b0;
        endcase
    end

    assign resp_any = (dmem2lsu_resp != SCR1_MEM_RESP_NOTRDY);
    assign pop      = (cnt != '0) && ((dmem2lsu_resp == SCR1_MEM_RESP_RDY_OK) ||
                                      (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER));

    // The count check also blocks a push when a pop frees a slot in the same cycle.
    assign lsu2dmem_req = exu2lsu_req & ~mis & (cnt < CNT_MAX);
    assign push         = lsu2dmem_req & dmem2lsu_req_ack;

    // A misaligned access retires only with nothing in flight, so it stays in order.
    assign mis_retire   = exu2lsu_req & mis & (cnt == '0) & ~resp_any;

    assign lsu2exu_req_ack = push | mis_retire;
    assign lsu_busy        = (cnt != '0);
    assign lsu2dmem_addr   = exu2lsu_addr[ADDR_W-1:0];
    assign lsu2dmem_cmd    = req_is_store ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;

    always_comb begin
        lsu2dmem_wdata = exu2lsu_s_data;
        lsu2dmem_width = SCR1_MEM_WIDTH_BYTE;
        case (exu2lsu_cmd)
            SCR1_LSU_CMD_SB: lsu2dmem_wdata = {4{exu2lsu_s_data[7:0]}};
            SCR1_LSU_CMD_SH: lsu2dmem_wdata = {2{exu2lsu_s_data[15:0]}};
            default:         lsu2dmem_wdata = exu2lsu_s_data;
        endcase
        // Width is parked at zero while the EXU is idle so the channel is all-zero.
        if (exu2lsu_req) begin
            case (exu2lsu_cmd)
                SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU, SCR1_LSU_CMD_SB: lsu2dmem_width = SCR1_MEM_WIDTH_BYTE;
                SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH: lsu2dmem_width = SCR1_MEM_WIDTH_HWORD;
                default:                                            lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
            endcase
        end
    end

    // ---------------- response side ----------------
    assign head_cmd      = tag_cmd[rd_ptr];
    assign head_off      = tag_off[rd_ptr];
    assign head_is_store = is_store(head_cmd);
    assign shifted       = dmem2lsu_rdata >> {head_off, 3'b000};

    always_comb begin
        lsu2exu_rdy      = 1'b0;
        lsu2exu_exc      = 1'b0;
        lsu2exu_exc_code = SCR1_EXC_CODE_INSTR_MISALIGN;
        lsu2exu_l_data   = '0;
        if (pop) begin
            lsu2exu_rdy = 1'b1;
            if (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER) begin
                lsu2exu_exc      = 1'b1;
                lsu2exu_exc_code = head_is_store ? SCR1_EXC_CODE_ST_ACCESS_FAULT
                                                 : SCR1_EXC_CODE_LD_ACCESS_FAULT;
            end else begin
                case (head_cmd)
                    SCR1_LSU_CMD_LB:  lsu2exu_l_data = {{24{shifted[7]}}, shifted[7:0]};
                    SCR1_LSU_CMD_LBU: lsu2exu_l_data = {24'd0, shifted[7:0]};
                    SCR1_LSU_CMD_LH:  lsu2exu_l_data = {{16{shifted[15]}}, shifted[15:0]};
                    SCR1_LSU_CMD_LHU: lsu2exu_l_data = {16'd0, shifted[15:0]};
                    SCR1_LSU_CMD_LW:  lsu2exu_l_data = shifted;
                    default:          lsu2exu_l_data = '0;
                endcase
            end
        end else if (mis_retire) begin
            lsu2exu_rdy      = 1'b1;
            lsu2exu_exc      = 1'b1;
            lsu2exu_exc_code = req_is_store ? SCR1_EXC_CODE_ST_ADDR_MISALIGN
                                            : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
        end
    end

    // ---------------- tag FIFO state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                tag_cmd[i] <= SCR1_LSU_CMD_NONE;
                tag_off[i] <= 2'd0;
            end
        end else begin
            if (push) begin
                tag_cmd[wr_ptr] <= exu2lsu_cmd;
                tag_off[wr_ptr] <= exu2lsu_addr[1:0];
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding (e.g. a stale one after reset) is dropped.
    always @(posedge clk) begin
        if (rst_n && (cnt == '0)) begin
            assert ((dmem2lsu_resp != SCR1_MEM_RESP_RDY_OK) && (dmem2lsu_resp != SCR1_MEM_RESP_RDY_ER))
            else $warning("scr1_pipe_lsu_pl: DMEM response with no outstanding request dropped");
        end
    end
`endif

endmodule

// File: doc/scr1_pipe_lsu_pl.md
# scr1_pipe_lsu_pl

Pipelined load/store unit for the SCR1 EXU-to-DMEM path. It supports up to `MAX_OUTST` in-flight DMEM transactions, which are tracked in an in-order tag FIFO, so issue does not wait for the previous response. It performs byte-lane alignment itself: store data is replicated across lanes, and load data is shifted, then sign- or zero-extended. It also detects misaligned accesses and DMEM access faults, and reports each as an exception.

## Interface
Parameters:
- `MAX_OUTST`, default 2: maximum outstanding DMEM transactions; legal range 1..4.
- `ADDR_W`, default `` `SCR1_DMEM_AWIDTH ``: DMEM address width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `exu2lsu_req`  in  1  access request; held until acknowledged.
- `exu2lsu_cmd`  in  `type_scr1_lsu_cmd_sel_e`  LB/LH/LW/LBU/LHU/SB/SH/SW.
- `exu2lsu_addr`  in  XLEN  byte address.
- `exu2lsu_s_data`  in  XLEN  store data, right-aligned.
- `lsu2exu_req_ack`  out  1  request consumed this cycle, either issued to DMEM or retired as a misalign exception.
- `lsu2exu_rdy`  out  1  one response valid this cycle.
- `lsu2exu_l_data`  out  XLEN  extended load data; 0 for stores and exceptions.
- `lsu2exu_exc`  out  1  response carries an exception.
- `lsu2exu_exc_code`  out  `type_scr1_exc_code_e`  exception cause.
- `lsu_busy`  out  1  outstanding count is non-zero.
- `lsu2dmem_req`, `lsu2dmem_cmd`, `lsu2dmem_width`, `lsu2dmem_addr`, `lsu2dmem_wdata`  out  DMEM request channel.
- `dmem2lsu_req_ack`, `dmem2lsu_rdata`, `dmem2lsu_resp`  in  DMEM acknowledge and response channel.

## Operation
Misalignment:
- `mis` = (LH/LHU/SH and `addr[0]`) or (LW/SW and `addr[1:0]` != 0).

Issue:
- `lsu2dmem_req` = `exu2lsu_req` & ~`mis` & (`cnt` < `MAX_OUTST`).
- The address passes through unmodified. `cmd` is RD for loads and WR for stores. `width` is BYTE/HWORD/WORD according to the command; a NONE command drives RD/WORD.
- Store data is replicated across lanes: SB gives `{4{d[7:0]}}`, SH gives `{2{d[15:0]}}`, SW gives `d`.
- `lsu2exu_req_ack` = `lsu2dmem_req` & `dmem2lsu_req_ack`. On acknowledge, the pair {cmd, addr[1:0]} is pushed to the tag FIFO.

Response:
- `dmem_resp` RDY_OK or RDY_ER with `cnt` > 0 pops the FIFO head and drives `lsu2exu_rdy`=1.
- On RDY_OK for a load, the data is computed as `rdata >> (8*head.addr[1:0])`, then extended: LB/LBU from bits [7:0], LH/LHU from bits [15:0], LW as a full word.
- RDY_ER raises `exc`=1 with `SCR1_EXC_CODE_LD_ACCESS_FAULT` for a load head or `SCR1_EXC_CODE_ST_ACCESS_FAULT` for a store head.
- A response arriving while `cnt`==0 is ignored and fires a simulation assertion.

Misalign retire:
- Preconditions: `exu2lsu_req` & `mis` & `cnt`==0 & no DMEM response this cycle.
- Result, all in the same cycle: `lsu2exu_req_ack`=1, `rdy`=1, `exc`=1, with code `SCR1_EXC_CODE_LD_ADDR_MISALIGN` for a load or `SCR1_EXC_CODE_ST_ADDR_MISALIGN` for a store. No DMEM request is made.
- If `cnt` > 0, the misaligned request waits until the FIFO drains, which preserves in-order responses.

Counting:
- Push and pop in the same cycle leave `cnt` unchanged.
- No push occurs while `cnt`==`MAX_OUTST`, even if a pop occurs that cycle.
- FIFO pointers wrap modulo `MAX_OUTST`.
- `cnt` width is clog2(`MAX_OUTST`+1).

## Timing
- Reset: `cnt`=0, FIFO pointers 0, FIFO entries become NONE. With no inputs active, every output is 0, `lsu2exu_exc_code` is `SCR1_EXC_CODE_INSTR_MISALIGN`, `lsu_busy`=0.
- All EXU and DMEM outputs are combinational from inputs and registered state. There is no added latency.
- Minimum load-to-use latency is one cycle, when the response arrives the cycle after acknowledge.
- Throughput is one issue per cycle while `cnt` < `MAX_OUTST`. With `MAX_OUTST`=1, throughput is one issue per two cycles.
- Responses reach the EXU in strict issue order, one per cycle at most.
- Reset asserted mid-transaction discards all tags. Responses arriving after reset release are dropped.

## Test plan
1. LW at 0x100 with ack, then RDY_OK with rdata 0xDEADBEEF one cycle later -> `rdy`=1, `l_data`=0xDEADBEEF, `exc`=0, `busy` 1 then 0.
2. LB at 0x103 with rdata 0x80FF_0000 -> `l_data`=0xFFFFFF80. LHU at 0x102 with rdata 0x80FF_0000 -> `l_data`=0x000080FF.
3. SB at 0x201 with s_data 0x12345678 -> `wdata`=0x78787878, width BYTE, cmd WR. A following RDY_ER -> `exc`=1, code ST_ACCESS_FAULT.
4. `MAX_OUTST`=2: three back-to-back LWs, ack always high, responses delayed 3 cycles -> the third is not acked until the first response, and data returns in order.
5. SH at 0x301 while `cnt`=1 -> no ack until the pending response pops. The next cycle gives `req_ack`=`rdy`=`exc`=1, code ST_ADDR_MISALIGN, `lsu2dmem_req`=0.
6. Push and pop in the same cycle at `cnt`=1 leave `cnt`=1. Asserting `rst_n` low with `cnt`=2 -> `busy`=0 immediately, and a later response is ignored.
